// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioner.
package button_pkg;

    // Per-channel press/repeat state.
    typedef enum logic [1:0] {
        BTN_IDLE    = 2'd0,
        BTN_PRESSED = 2'd1,
        BTN_REPEAT  = 2'd2
    } btn_state_t;

    // Default timing at a 100 MHz system clock.
    localparam int DB_10MS      = 1_000_000;
    localparam int HOLD_500MS   = 50_000_000;
    localparam int REPEAT_100MS = 10_000_000;

    // Counter width for a terminal count of v-1, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, stability-counter debounce, and the
// press / hold-to-repeat / release pulse generator.
module button_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES     = DB_10MS,
    parameter int HOLD_CYCLES   = HOLD_500MS,
    parameter int REPEAT_CYCLES = REPEAT_100MS
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_level,
    output logic o_pulse,
    output logic o_release
);

    localparam int DBW = cnt_width(DB_CYCLES);
    localparam int RPW = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [RPW-1:0] HOLD_LAST = RPW'(HOLD_CYCLES - 1);
    localparam logic [RPW-1:0] REP_LAST  = RPW'(REPEAT_CYCLES - 1);

    logic           r_s1;
    logic           r_s2;
    logic           r_level;
    logic [DBW-1:0] r_db_cnt;
    logic [RPW-1:0] r_rp_cnt;
    logic           r_pulse;
    logic           r_release;
    btn_state_t     r_state;

    logic           w_sync;
    logic           w_flip;
    logic           w_rise;
    logic           w_fall;
    btn_state_t     w_state_nxt;
    logic [RPW-1:0] w_rp_cnt_nxt;
    logic           w_pulse_nxt;
    logic           w_release_nxt;

    assign w_sync = r_s2;
    // The level flips on the DB_CYCLES-th consecutive cycle that sync disagrees.
    assign w_flip = (w_sync != r_level) && (r_db_cnt == DB_LAST);
    assign w_rise = w_flip & ~r_level;
    assign w_fall = w_flip &  r_level;

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
        end
    end

    // Debounce: count cycles of disagreement, restart on any agreement.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_level  <= 1'b0;
            r_db_cnt <= '0;
        end else if (w_sync == r_level) begin
            r_db_cnt <= '0;
        end else if (w_flip) begin
            r_level  <= ~r_level;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Next state and pulses; a falling level overrides any repeat due that cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_rp_cnt_nxt  = r_rp_cnt;
        w_pulse_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_fall) begin
            w_release_nxt = 1'b1;
            w_state_nxt   = BTN_IDLE;
            w_rp_cnt_nxt  = '0;
        end else begin
            case (r_state)
                BTN_IDLE: begin
                    if (w_rise) begin
                        w_pulse_nxt  = 1'b1;
                        w_rp_cnt_nxt = '0;
                        w_state_nxt  = BTN_PRESSED;
                    end
                end
                BTN_PRESSED: begin
                    if (!i_repeat_en) begin
                        w_rp_cnt_nxt = '0;
                    end else if (r_rp_cnt == HOLD_LAST) begin
                        w_pulse_nxt  = 1'b1;
                        w_rp_cnt_nxt = '0;
                        w_state_nxt  = BTN_REPEAT;
                    end else begin
                        w_rp_cnt_nxt = r_rp_cnt + 1'b1;
                    end
                end
                BTN_REPEAT: begin
                    if (!i_repeat_en) begin
                        w_rp_cnt_nxt = '0;
                        w_state_nxt  = BTN_PRESSED;
                    end else if (r_rp_cnt == REP_LAST) begin
                        w_pulse_nxt  = 1'b1;
                        w_rp_cnt_nxt = '0;
                    end else begin
                        w_rp_cnt_nxt = r_rp_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = BTN_IDLE;
                    w_rp_cnt_nxt = '0;
                end
            endcase
        end
    end

    // FSM state, repeat counter and registered pulse outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= BTN_IDLE;
            r_rp_cnt  <= '0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_rp_cnt  <= w_rp_cnt_nxt;
            r_pulse   <= w_pulse_nxt;
            r_release <= w_release_nxt;
        end
    end

    assign o_level   = r_level;
    assign o_pulse   = r_pulse;
    assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: one independent conditioner per button.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N             = 3,
    parameter int DB_CYCLES     = DB_10MS,
    parameter int HOLD_CYCLES   = HOLD_500MS,
    parameter int REPEAT_CYCLES = REPEAT_100MS
)(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_btn_in,
    input  logic [N-1:0] i_repeat_en,
    output logic [N-1:0] o_btn_level,
    output logic [N-1:0] o_btn_pulse,
    output logic [N-1:0] o_btn_release
);

    for (genvar g = 0; g < N; g++) begin : g_ch
        button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_btn      (i_btn_in[g]),
            .i_repeat_en(i_repeat_en[g]),
            .o_level    (o_btn_level[g]),
            .o_pulse    (o_btn_pulse[g]),
            .o_release  (o_btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_button_conditioner;

    localparam int N    = 3;
    localparam int DB   = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in    = '0;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] level;
    logic [N-1:0] pulse;
    logic [N-1:0] rel;

    always #5 clk = ~clk;

    button_conditioner #(
        .N(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn_in(btn_in), .i_repeat_en(repeat_en),
        .o_btn_level(level), .o_btn_pulse(pulse), .o_btn_release(rel)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Behavioural model state: per channel, the two-sample input delay, the
    // run of samples disagreeing with the level, the run of enabled cycles
    // since the last pulse anchor, and whether the first repeat has happened.
    bit [N-1:0]   m_d1, m_d2, m_level, m_held, m_rep;
    int           m_diff [N];
    int           m_run  [N];
    logic [N-1:0] e_level = '0, e_pulse = '0, e_rel = '0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model by the clock edge that just happened, using the
    // inputs that were stable across it.
    task automatic model_step();
        bit sync;
        bit flip;
        int lim;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_level = '0; m_held = '0; m_rep = '0;
            for (int i = 0; i < N; i++) begin
                m_diff[i] = 0;
                m_run[i]  = 0;
            end
            e_level = '0; e_pulse = '0; e_rel = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sync     = m_d2[i];
                m_d2[i]  = m_d1[i];
                m_d1[i]  = btn_in[i];
                m_diff[i] = (sync != m_level[i]) ? m_diff[i] + 1 : 0;
                flip = (m_diff[i] == DB);
                if (flip) m_diff[i] = 0;
                e_pulse[i] = 1'b0;
                e_rel[i]   = 1'b0;
                if (flip && m_level[i]) begin
                    e_rel[i] = 1'b1; m_held[i] = 1'b0; m_rep[i] = 1'b0; m_run[i] = 0;
                end else if (flip) begin
                    e_pulse[i] = 1'b1; m_held[i] = 1'b1; m_rep[i] = 1'b0; m_run[i] = 0;
                end else if (m_held[i]) begin
                    if (!repeat_en[i]) begin
                        m_run[i] = 0; m_rep[i] = 1'b0;
                    end else begin
                        m_run[i]++;
                        lim = m_rep[i] ? REP : HOLD;
                        if (m_run[i] == lim) begin
                            e_pulse[i] = 1'b1; m_run[i] = 0; m_rep[i] = 1'b1;
                        end
                    end
                end
                if (flip) m_level[i] = ~m_level[i];
                e_level[i] = m_level[i];
            end
        end
    endtask

    // One cycle: wait for the falling edge, update the model, compare outputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        model_step();
        check("model_level",   int'(level), int'(e_level));
        check("model_pulse",   int'(pulse), int'(e_pulse));
        check("model_release", int'(rel),   int'(e_rel));
    endtask

    int n;
    int rel_cnt;
    int offs[$];
    int exp_offs[7] = '{6, 16, 19, 22, 25, 28, 31};
    int fast;

    initial begin
        repeat (3) tick();
        check("reset_level",   int'(level), 0);
        check("reset_pulse",   int'(pulse), 0);
        check("reset_release", int'(rel),   0);
        rst = 1'b0;
        tick();

        // Clean press on ch0, no repeat.
        btn_in[0] = 1'b1;
        repeat (5) tick();
        check("press_level_early", int'(level[0]), 0);
        tick();
        check("press_level", int'(level[0]), 1);
        check("press_pulse", int'(pulse[0]), 1);
        tick();
        check("press_pulse_width", int'(pulse[0]), 0);
        repeat (4) tick();
        btn_in[0] = 1'b0;
        repeat (5) tick();
        check("release_early", int'(rel[0]), 0);
        tick();
        check("release_pulse", int'(rel[0]), 1);
        check("release_level", int'(level[0]), 0);
        tick();
        check("release_width", int'(rel[0]), 0);
        repeat (4) tick();

        // Bounce on ch1: 1,1,0,0,1,1,0,0 then steady 1.
        n = 0;
        for (int k = 0; k < 8; k++) begin
            btn_in[1] = ((k % 4) < 2);
            tick();
            n += int'(pulse[1]);
        end
        btn_in[1] = 1'b1;
        repeat (20) begin
            tick();
            n += int'(pulse[1]);
        end
        check("bounce_pulse_count", n, 1);
        check("bounce_level", int'(level[1]), 1);
        btn_in[1] = 1'b0;
        repeat (10) tick();

        // Three-cycle glitch on ch2.
        n = 0;
        btn_in[2] = 1'b1;
        repeat (3) begin
            tick();
            n += int'(level[2]) + int'(pulse[2]) + int'(rel[2]);
        end
        btn_in[2] = 1'b0;
        repeat (12) begin
            tick();
            n += int'(level[2]) + int'(pulse[2]) + int'(rel[2]);
        end
        check("glitch_activity", n, 0);

        // Auto-repeat on ch0.
        repeat_en[0] = 1'b1;
        btn_in[0]    = 1'b1;
        offs.delete();
        for (int j = 1; j <= 31; j++) begin
            tick();
            if (pulse[0]) offs.push_back(j);
        end
        check("repeat_pulse_count", offs.size(), 7);
        for (int k = 0; k < 7 && k < offs.size(); k++)
            check("repeat_pulse_offset", offs[k], exp_offs[k]);
        btn_in[0] = 1'b0;
        rel_cnt = 0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            rel_cnt += int'(rel[0]);
            if (j == 3) check("repeat_before_release", int'(pulse[0]), 1);
            if (j == 6) begin
                check("release_after_repeat", int'(rel[0]), 1);
                check("release_beats_repeat", int'(pulse[0]), 0);
            end
        end
        check("release_count", rel_cnt, 1);
        repeat (5) tick();

        // Drop repeat_en while repeating, re-enable five cycles later.
        btn_in[0] = 1'b1;
        repeat (17) tick();
        repeat_en[0] = 1'b0;
        n = 0;
        repeat (5) begin
            tick();
            n += int'(pulse[0]);
        end
        repeat_en[0] = 1'b1;
        repeat (9) begin
            tick();
            n += int'(pulse[0]);
        end
        check("no_pulse_while_disabled", n, 0);
        tick();
        check("pulse_after_reenable", int'(pulse[0]), 1);

        // One-cycle reset while repeating with the button held.
        tick();
        rst = 1'b1;
        tick();
        check("midrst_level",   int'(level), 0);
        check("midrst_pulse",   int'(pulse), 0);
        check("midrst_release", int'(rel),   0);
        rst = 1'b0;
        n = 0;
        repeat (5) begin
            tick();
            n += int'(pulse[0]) + int'(level[0]);
        end
        check("postrst_quiet", n, 0);
        tick();
        check("postrst_pulse", int'(pulse[0]), 1);
        btn_in = '0;
        repeat (10) tick();

        // Randomized traffic, alternating fast- and slow-toggling blocks.
        for (int blk = 0; blk < 8; blk++) begin
            fast = blk % 2;
            for (int c = 0; c < 400; c++) begin
                for (int i = 0; i < N; i++) begin
                    if ($urandom_range(0, fast ? 5 : 24) == 0) btn_in[i] = ~btn_in[i];
                    if ($urandom_range(0, 59) == 0) repeat_en[i] = ~repeat_en[i];
                end
                rst = ($urandom_range(0, 799) == 0);
                tick();
            end
        end
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
